// File: rtl/tail_light_pkg.sv
// Shared state codes, LED field positions and the sweep-code helper for the tail-light block.
// The state codes are also used by the upstream next-state logic.
package tail_light_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        HAZARD  = 4'd1,
        TURN    = 4'd2,
        BRAKE   = 4'd3,
        RIGHT   = 4'd4,
        LEFT    = 4'd5,
        B_RIGHT = 4'd6,
        B_LEFT  = 4'd7
    } tl_state_e;

    localparam int LEFT_HI  = 9;
    localparam int LEFT_LO  = 7;
    localparam int RIGHT_HI = 2;
    localparam int RIGHT_LO = 0;

    // Thermometer code that grows by one lamp per step; bit0 is the innermost lamp.
    function automatic logic [2:0] sweep_code(input logic [1:0] s);
        logic [2:0] code;
        case (s)
            2'd0:    code = 3'b000;
            2'd1:    code = 3'b001;
            2'd2:    code = 3'b011;
            default: code = 3'b111;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tail_light_sequencer_step_tick_gen.sv
// Step prescaler: emits a one-cycle tick every TICK_DIV clocks; clr restarts the count
// and suppresses a tick that would otherwise fire in the same cycle.
module step_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;
    logic          at_max;

    assign at_max = (p_q == P_MAX);
    assign tick   = at_max && !clr;

    always_comb begin
        p_d = p_q + PW'(1);
        if (clr || at_max) begin
            p_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light output stage: turns the registered state code into timed LED patterns.
// Define TAIL_LIGHT_STATE_DISPLAY_EN to mirror the sampled state code on LEDR[6:3].
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int STEP_HZ = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       reset_counter,
    output logic [9:0] LEDR
);

    localparam int TICK_DIV = (STEP_HZ > 0) ? (CLK_HZ / STEP_HZ) : 0;

    generate
        if (STEP_HZ <= 0 || (CLK_HZ % ((STEP_HZ > 0) ? STEP_HZ : 1)) != 0 || TICK_DIV < 2) begin : g_bad_cfg
            $error("tail_light_sequencer: CLK_HZ must be a multiple of STEP_HZ with CLK_HZ/STEP_HZ >= 2");
        end
    endgenerate

    logic       restart;
    logic       tick;
    logic [1:0] s_q, s_d;
    logic       b_q, b_d;
    logic [3:0] ps_q, ps_d;
    logic [2:0] left_q, left_d;
    logic [2:0] right_q, right_d;
    logic [2:0] swp;
    logic [2:0] swp_right;
    logic [3:0] disp;

    // A state change or a low reset_counter strobe both restart the sweep from step 0.
    assign restart = !reset_counter || (state != ps_q);

    step_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (restart),
        .tick(tick)
    );

    always_comb begin
        s_d  = s_q;
        b_d  = b_q;
        ps_d = state;
        if (restart) begin
            s_d = 2'd0;
            b_d = 1'b0;
        end else if (tick) begin
            s_d = s_q + 2'd1;
            b_d = ~b_q;
        end
    end

    // Patterns are built from the post-edge step and phase so LEDR follows the state in one cycle.
    assign swp       = sweep_code(s_d);
    assign swp_right = {swp[0], swp[1], swp[2]};

    always_comb begin
        left_d  = 3'b000;
        right_d = 3'b000;
        case (state)
            HAZARD: begin
                left_d  = b_d ? 3'b000 : 3'b111;
                right_d = b_d ? 3'b000 : 3'b111;
            end
            BRAKE: begin
                left_d  = 3'b111;
                right_d = 3'b111;
            end
            LEFT:    left_d = swp;
            RIGHT:   right_d = swp_right;
            B_LEFT: begin
                left_d  = swp;
                right_d = 3'b111;
            end
            B_RIGHT: begin
                left_d  = 3'b111;
                right_d = swp_right;
            end
            default: begin
                left_d  = 3'b000;
                right_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 2'd0;
            b_q     <= 1'b0;
            ps_q    <= IDLE;
            left_q  <= 3'b000;
            right_q <= 3'b000;
        end else begin
            s_q     <= s_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

`ifdef TAIL_LIGHT_STATE_DISPLAY_EN
    logic [3:0] disp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= 4'd0;
        end else begin
            disp_q <= state;
        end
    end

    assign disp = disp_q;
`else
    assign disp = 4'd0;
`endif

    always_comb begin
        LEDR                    = {3'b000, disp, 3'b000};
        LEDR[LEFT_HI:LEFT_LO]   = left_q;
        LEDR[RIGHT_HI:RIGHT_LO] = right_q;
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer at CLK_HZ=8, STEP_HZ=2 (four clocks per step).
module tb_tail_light_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] state;
    logic       reset_counter;
    logic [9:0] LEDR;

    int checks;
    int failures;

    logic [2:0] left_tab [4];
    logic [2:0] right_tab[4];

    tail_light_sequencer #(
        .CLK_HZ (8),
        .STEP_HZ(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .reset_counter(reset_counter),
        .LEDR         (LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_disp(input logic [3:0] st);
`ifdef TAIL_LIGHT_STATE_DISPLAY_EN
        return st;
`else
        return 4'd0;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold rst for two edges with the given inputs, release 1 ns after an edge.
    task automatic do_reset(input logic [3:0] st);
        state         = st;
        reset_counter = 1'b1;
        rst           = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        state         = 4'd3;
        reset_counter = 1'b1;
        rst           = 1'b1;
        #2;
        checks++;
        if (LEDR !== 10'd0) begin
            failures++;
            $display("FAIL reset_initial LEDR=%h expected=%h", LEDR, 10'd0);
        end
        cycle();
        checks++;
        if (LEDR !== 10'd0) begin
            failures++;
            $display("FAIL reset_held LEDR=%h expected=%h", LEDR, 10'd0);
        end
    endtask

    task automatic test_left_sweep();
        logic [2:0] exp_l;
        do_reset(4'd5);
        for (int e = 1; e <= 17; e++) begin
            cycle();
            exp_l = left_tab[((e - 1) / 4) % 4];
            checks++;
            if (LEDR[9:7] !== exp_l || LEDR[2:0] !== 3'b000) begin
                failures++;
                $display("FAIL left_sweep edge=%0d LEDR=%b expected left=%b right=000", e, LEDR, exp_l);
            end
        end
    endtask

    task automatic test_right_sweep();
        logic [2:0] exp_r;
        do_reset(4'd4);
        for (int e = 1; e <= 17; e++) begin
            cycle();
            exp_r = right_tab[((e - 1) / 4) % 4];
            checks++;
            if (LEDR[2:0] !== exp_r || LEDR[9:7] !== 3'b000) begin
                failures++;
                $display("FAIL right_sweep edge=%0d LEDR=%b expected right=%b left=000", e, LEDR, exp_r);
            end
        end
    endtask

    task automatic test_hazard();
        logic [2:0] exp_h;
        do_reset(4'd1);
        for (int e = 1; e <= 16; e++) begin
            cycle();
            exp_h = ((((e - 1) / 4) % 2) == 0) ? 3'b111 : 3'b000;
            checks++;
            if (LEDR[9:7] !== exp_h || LEDR[2:0] !== exp_h) begin
                failures++;
                $display("FAIL hazard edge=%0d LEDR=%b expected both=%b", e, LEDR, exp_h);
            end
        end
    endtask

    task automatic test_bleft_restart();
        do_reset(4'd7);
        repeat (9) cycle();
        checks++;
        if (LEDR[9:7] !== 3'b011 || LEDR[2:0] !== 3'b111) begin
            failures++;
            $display("FAIL bleft_mid LEDR=%b expected left=011 right=111", LEDR);
        end
        reset_counter = 1'b0;
        cycle();
        reset_counter = 1'b1;
        checks++;
        if (LEDR[9:7] !== 3'b000 || LEDR[2:0] !== 3'b111) begin
            failures++;
            $display("FAIL bleft_strobe LEDR=%b expected left=000 right=111", LEDR);
        end
        for (int e = 1; e <= 4; e++) begin
            cycle();
            checks++;
            if (LEDR[9:7] !== ((e == 4) ? 3'b001 : 3'b000) || LEDR[2:0] !== 3'b111) begin
                failures++;
                $display("FAIL bleft_after_strobe edge=%0d LEDR=%b expected left=%b right=111",
                         e, LEDR, (e == 4) ? 3'b001 : 3'b000);
            end
        end
    endtask

    task automatic test_restart_beats_tick();
        do_reset(4'd4);
        repeat (4) cycle();
        state = 4'd6;
        cycle();
        checks++;
        if (LEDR[2:0] !== 3'b000 || LEDR[9:7] !== 3'b111) begin
            failures++;
            $display("FAIL restart_vs_tick LEDR=%b expected left=111 right=000", LEDR);
        end
        for (int e = 1; e <= 4; e++) begin
            cycle();
            checks++;
            if (LEDR[2:0] !== ((e == 4) ? 3'b100 : 3'b000) || LEDR[9:7] !== 3'b111) begin
                failures++;
                $display("FAIL bright_after_restart edge=%0d LEDR=%b expected right=%b left=111",
                         e, LEDR, (e == 4) ? 3'b100 : 3'b000);
            end
        end
    endtask

    task automatic test_brake_async_reset();
        logic [9:0] exp_v;
        state = 4'd3;
        exp_v = {3'b111, exp_disp(4'd3), 3'b111};
        for (int e = 1; e <= 20; e++) begin
            cycle();
            checks++;
            if (LEDR !== exp_v) begin
                failures++;
                $display("FAIL brake edge=%0d LEDR=%h expected=%h", e, LEDR, exp_v);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (LEDR !== 10'd0) begin
            failures++;
            $display("FAIL async_reset LEDR=%h expected=%h", LEDR, 10'd0);
        end
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_off_codes_and_display();
        logic [3:0] codes[5];
        codes[0] = 4'd2;
        codes[1] = 4'd0;
        codes[2] = 4'd9;
        codes[3] = 4'd15;
        codes[4] = 4'd6;
        do_reset(4'd0);
        for (int i = 0; i < 5; i++) begin
            state = codes[i];
            cycle();
            checks++;
            if (LEDR[6:3] !== exp_disp(codes[i])) begin
                failures++;
                $display("FAIL display code=%0d LEDR[6:3]=%b expected=%b", codes[i], LEDR[6:3], exp_disp(codes[i]));
            end
            if (i < 4) begin
                checks++;
                if (LEDR[9:7] !== 3'b000 || LEDR[2:0] !== 3'b000) begin
                    failures++;
                    $display("FAIL off_code code=%0d LEDR=%b expected lamps off", codes[i], LEDR);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        left_tab[0]  = 3'b000;
        left_tab[1]  = 3'b001;
        left_tab[2]  = 3'b011;
        left_tab[3]  = 3'b111;
        right_tab[0] = 3'b000;
        right_tab[1] = 3'b100;
        right_tab[2] = 3'b110;
        right_tab[3] = 3'b111;
        rst           = 1'b1;
        state         = 4'd0;
        reset_counter = 1'b1;

        test_reset();
        test_left_sweep();
        test_right_sweep();
        test_hazard();
        test_bleft_restart();
        test_restart_beats_tick();
        test_brake_async_reset();
        test_off_codes_and_display();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
